// File: rtl/bopit_pkg.sv
// Shared types and constants for the button input path of the game.
package bopit_pkg;

    localparam int unsigned NUM_BTN_DEFAULT = 4;

    typedef enum logic {
        IDLE,
        PRESENT
    } arb_state_t;

    localparam int unsigned BTN_BOP   = 0;
    localparam int unsigned BTN_TWIST = 1;
    localparam int unsigned BTN_PULL  = 2;
    localparam int unsigned BTN_SPIN  = 3;

endpackage

// File: rtl/button_event_arbiter_rr.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int unsigned NUM_BTN = 4,
    localparam int unsigned IDW     = $clog2(NUM_BTN)
) (
    input  logic [NUM_BTN-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_BTN-1:0] gnt_onehot,
    output logic [IDW-1:0]     gnt_idx,
    output logic               gnt_any
);

    localparam int unsigned SW = IDW + 1;

    logic [NUM_BTN-1:0] rot;
    logic [IDW-1:0]     off;
    logic [SW-1:0]      sum;

    // Rotate the doubled request vector so bit 0 is the ptr position.
    always_comb begin
        rot = NUM_BTN'({req, req} >> ptr);
        off = '0;
        for (int j = NUM_BTN - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = IDW'(j);
            end
        end
        sum = SW'(ptr) + SW'(off);
        if (sum >= SW'(NUM_BTN)) begin
            sum = sum - SW'(NUM_BTN);
        end
        gnt_idx    = IDW'(sum);
        gnt_any    = |req;
        gnt_onehot = gnt_any ? (NUM_BTN'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Turns debounced button levels into a one-at-a-time stream of press events
// with sticky pending requests and round-robin service.
module button_event_arbiter
    import bopit_pkg::*;
#(
    parameter  int unsigned NUM_BTN = NUM_BTN_DEFAULT,
    localparam int unsigned IDW     = $clog2(NUM_BTN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_db,
    input  logic               enable,
    output logic               evt_valid,
    output logic [IDW-1:0]     evt_id,
    input  logic               evt_ready,
    output logic               overrun,
    output logic [NUM_BTN-1:0] pending
);

    arb_state_t         state, state_n;
    logic [NUM_BTN-1:0] prev;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] pending_n;
    logic [NUM_BTN-1:0] gnt_onehot;
    logic [NUM_BTN-1:0] gnt_c;
    logic [IDW-1:0]     gnt_idx;
    logic               gnt_any;
    logic [IDW-1:0]     ptr, ptr_n;
    logic [IDW-1:0]     evt_id_n;
    logic               evt_valid_n;
    logic               overrun_n;

    assign rise = btn_db & ~prev;

    rr_arbiter #(.NUM_BTN(NUM_BTN)) u_rr (
        .req        (pending),
        .ptr        (ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .gnt_any    (gnt_any)
    );

    // History resets to all ones so buttons held through reset never fire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prev      <= '1;
            pending   <= '0;
            ptr       <= '0;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            prev      <= btn_db;
            pending   <= pending_n;
            ptr       <= ptr_n;
            evt_valid <= evt_valid_n;
            evt_id    <= evt_id_n;
            overrun   <= overrun_n;
        end
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        evt_valid_n = evt_valid;
        evt_id_n    = evt_id;
        gnt_c       = '0;
        case (state)
            IDLE: begin
                if (enable && gnt_any) begin
                    gnt_c       = gnt_onehot;
                    evt_valid_n = 1'b1;
                    evt_id_n    = gnt_idx;
                    ptr_n       = (gnt_idx == IDW'(NUM_BTN - 1)) ? '0 : gnt_idx + IDW'(1);
                    state_n     = PRESENT;
                end
            end
            PRESENT: begin
                if (evt_ready) begin
                    evt_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // A granted bit clears unless a fresh press arrives in the same cycle.
        pending_n = enable ? ((pending & ~gnt_c) | rise) : '0;
        overrun_n = enable & (|(rise & pending & ~gnt_c));
    end

endmodule
